// File: rtl/bht_update_fifo.sv
// Buffers resolved conditional branches and issues them one per cycle to the BHT.
// Also keeps saturating counts of resolved branches and mispredictions.
module bht_update_fifo #(
   parameter int VLEN  = 64,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             resolve_valid_i,
   output logic             resolve_ready_o,
   input  logic [VLEN-1:0]  resolve_pc_i,
   input  logic             resolve_taken_i,
   input  logic             resolve_pred_taken_i,
   input  logic             bht_busy_i,
   input  logic             flush_i,
   output logic             bht_update_valid_o,
   output logic [VLEN-1:0]  bht_update_pc_o,
   output logic             bht_update_taken_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispredict_cnt_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [VLEN-1:0]  r_mem_pc [DEPTH];
   logic [DEPTH-1:0] r_mem_taken;
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mispred_cnt;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_mispred;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push    = resolve_valid_i & ~w_full & ~flush_i;
   assign w_pop     = ~w_empty & ~bht_busy_i & ~flush_i;
   assign w_mispred = resolve_taken_i ^ resolve_pred_taken_i;

   assign resolve_ready_o    = ~w_full;
   assign bht_update_valid_o = w_pop;
   assign bht_update_pc_o    = r_mem_pc[r_rptr[AW-1:0]];
   assign bht_update_taken_o = r_mem_taken[r_rptr[AW-1:0]];
   assign branch_cnt_o       = r_branch_cnt;
   assign mispredict_cnt_o   = r_mispred_cnt;
   assign empty_o            = w_empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage is cleared on reset so the update port reads zero afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem_pc[i] <= '0;
         r_mem_taken <= '0;
      end else if (w_push) begin
         r_mem_pc[r_wptr[AW-1:0]]    <= resolve_pc_i;
         r_mem_taken[r_wptr[AW-1:0]] <= resolve_taken_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (w_push) begin
         if (r_branch_cnt != '1)
            r_branch_cnt <= r_branch_cnt + 1'b1;
         if (w_mispred && r_mispred_cnt != '1)
            r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
   end

endmodule

// File: doc/bht_update_fifo.md
Name: bht_update_fifo

Overview:
- Execute-side producer of BHT update traffic; it drives the update port that the BHT consumes.
- Accepts resolved conditional branches from the branch unit through a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one update per cycle to the BHT, and holds issue while the BHT signals busy.
- Keeps saturating counts of resolved branches and mispredictions for performance monitoring.

Parameters:
VLEN, 64, virtual address width of branch PC
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 32, width of the performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
resolve_valid_i  in  1  resolved conditional branch offered
resolve_ready_o  out  1  block can accept a branch this cycle
resolve_pc_i  in  VLEN  branch PC
resolve_taken_i  in  1  actual outcome
resolve_pred_taken_i  in  1  outcome predicted by the frontend
bht_busy_i  in  1  BHT cannot take an update this cycle
flush_i  in  1  discard all buffered updates
bht_update_valid_o  out  1  update valid; fields map onto bht_update_t.valid
bht_update_pc_o  out  VLEN  update PC; fields map onto bht_update_t.pc
bht_update_taken_o  out  1  update outcome; fields map onto bht_update_t.taken
branch_cnt_o  out  CNT_W  accepted branches, saturating
mispredict_cnt_o  out  CNT_W  accepted branches with taken != pred_taken, saturating
empty_o  out  1  FIFO empty

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; read and write pointers 0.
  - resolve_ready_o=1, bht_update_valid_o=0, bht_update_pc_o=0, bht_update_taken_o=0.
  - Both counters 0; empty_o=1.
- Storage:
  - Circular buffer of DEPTH entries {pc, taken}.
  - Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty, and the pointers wrap modulo 2*DEPTH.
- Accept:
  - Handshake fires when resolve_valid_i & resolve_ready_o at a rising edge.
  - resolve_ready_o = !full. It is purely registered-state based: a full FIFO does not accept even in a cycle where it pops.
  - Inputs are ignored unless the handshake fires.
- Issue:
  - bht_update_valid_o = !empty & !bht_busy_i & !flush_i.
  - pc/taken are driven from the head entry, and are held at the head value even when valid=0.
  - The head is popped at the edge where bht_update_valid_o=1.
- Latency: a branch accepted at edge N is visible on the update port in the cycle after edge N. There is no same-cycle bypass.
- Push and pop together (not full, not empty): both happen; occupancy is unchanged.
- flush_i:
  - At the edge, both pointers reset to 0 and any push in that cycle is discarded.
  - bht_update_valid_o=0 in the flush cycle.
  - Counters are not affected by flush, except that the discarded push is not counted.
- Counters:
  - On each accepted handshake, branch_cnt increments.
  - mispredict_cnt increments if resolve_taken_i != resolve_pred_taken_i.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Order: updates are issued in strict acceptance order.
- Reset mid-operation: all buffered entries are lost, outputs return to reset values immediately, and counters clear.

Test Plan:
- Single branch: accept pc=0x8000_0010 taken=1 pred=1 at edge 1 -> update valid in cycle 2 with pc=0x8000_0010, taken=1; branch_cnt=1, mispredict_cnt=0; empty_o=1 after edge 2.
- Fill with bht_busy_i=1: push DEPTH=4 branches -> resolve_ready_o=0 after the 4th; a 5th offered branch is held. Drop busy -> 4 updates issue on consecutive cycles in order; ready=1 after the first pop.
- Wrap-around: 10 back-to-back branches with busy=0, pcs 0x100..0x124 step 4 -> 10 updates in order with no loss; pointers wrap at least twice.
- Mispredict count: 6 branches with taken/pred pairs (1,0),(0,0),(0,1),(1,1),(1,0),(0,0) -> branch_cnt=6, mispredict_cnt=3.
- Flush with 3 entries and a push in the same cycle -> empty_o=1 next cycle, no update issued, the pushed branch is not counted, and counters keep their prior values.
- Saturation with CNT_W=4: 17 accepted mispredicting branches -> both counters stay at 15. Reset mid-stream with entries buffered -> valid=0 and counters 0 while rst_i=1.
